// File: rtl/fetch_unit_pkg.sv
// Shared fetch/pipeline constants: widths, reset PC, HLT encoding,
// and the control-flow opcodes the SCU decodes.
package fetch_unit_pkg;

  localparam int FU_ADDR_W   = 10;
  localparam int FU_DATA_W   = 32;
  localparam int FU_RESET_PC = 0;

  localparam logic [31:0] FU_HLT_WORD = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  typedef struct packed {
    logic [FU_DATA_W-1:0] instr;
    logic [FU_ADDR_W-1:0] pc;
    logic                 valid;
  } if_id_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// Fetch performance counters: delivered instructions and stall cycles.
// Both are free-running 32-bit counters that wrap silently.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_inc_i,
  input  logic        stall_inc_i,
  output logic [31:0] fetch_count_o,
  output logic [31:0] stall_count_o
);

  logic [31:0] fetch_q, fetch_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    fetch_d = fetch_q;
    stall_d = stall_q;
    if (fetch_inc_i) fetch_d = fetch_q + 32'd1;
    if (stall_inc_i) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      fetch_q <= fetch_d;
      stall_q <= stall_d;
    end
  end

  assign fetch_count_o = fetch_q;
  assign stall_count_o = stall_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives the 1-cycle imem, pairs data with PC into IF/ID.
// Optional FETCH_PERF_EN adds fetch/stall counters (tied to 0 otherwise).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              ADDR_W   = FU_ADDR_W,
  parameter int              DATA_W   = FU_DATA_W,
  parameter int              RESET_PC = FU_RESET_PC,
  parameter logic [DATA_W-1:0] HLT_WORD = DATA_W'(FU_HLT_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] direccion,
  input  logic [DATA_W-1:0] instruccion,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_valid,
  output logic              halted,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              req_valid_q, req_valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              adv;

  assign adv = !redirect && !stall && !halted_q;

  // Stall/halt re-present req_pc so the memory keeps the pending word.
  always_comb begin
    direccion = pc_q;
    if (redirect)
      direccion = redirect_target;
    else if (halted_q || stall)
      direccion = req_pc_q;
  end

  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    instr_d     = instr_q;
    ifpc_d      = ifpc_q;
    valid_d     = valid_q;
    halted_d    = halted_q;
    if (redirect) begin
      req_pc_d    = redirect_target;
      req_valid_d = 1'b1;
      pc_d        = redirect_target + ADDR_W'(1);
      valid_d     = 1'b0;
      halted_d    = 1'b0;
    end else if (adv) begin
      instr_d     = instruccion;
      ifpc_d      = req_pc_q;
      valid_d     = req_valid_q;
      req_pc_d    = pc_q;
      req_valid_d = 1'b1;
      pc_d        = pc_q + ADDR_W'(1);
      halted_d    = req_valid_q && (instruccion == HLT_WORD);
    end else if (!stall) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RST_PC;
      req_pc_q    <= RST_PC;
      req_valid_q <= 1'b0;
      instr_q     <= '0;
      ifpc_q      <= '0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      instr_q     <= instr_d;
      ifpc_q      <= ifpc_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
    end
  end

  assign if_instr = instr_q;
  assign if_pc    = ifpc_q;
  assign if_valid = valid_q;
  assign halted   = halted_q;

`ifdef FETCH_PERF_EN
  logic fetch_inc;
  logic stall_inc;

  assign fetch_inc = adv && req_valid_q;
  assign stall_inc = stall && !redirect;

  fetch_perf_counters u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_inc_i  (fetch_inc),
    .stall_inc_i  (stall_inc),
    .fetch_count_o(fetch_count),
    .stall_count_o(stall_count)
  );
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/redirect/reset
// traffic against a delivered-instruction-stream reference model.
module tb_fetch_unit;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int AW   = 10;
  localparam int NMEM = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] direccion;
  logic [31:0]   instruccion;
  logic          stall;
  logic          redirect;
  logic [AW-1:0] redirect_target;
  logic [31:0]   if_instr;
  logic [AW-1:0] if_pc;
  logic          if_valid;
  logic          halted;
  logic [31:0]   fetch_count;
  logic [31:0]   stall_count;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .direccion      (direccion),
    .instruccion    (instruccion),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_valid       (if_valid),
    .halted         (halted),
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [NMEM];

  always @(posedge clk) instruccion <= mem[direccion];

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: the stream of words decode should see.
  // nxt = next address to deliver, lead = bubble edges before it.
  int          m_nxt;
  int          m_lead;
  bit          m_halt;
  bit          m_ov;
  int          m_opc;
  logic [31:0] m_oi;
  int          m_fc;
  int          m_sc;

  task automatic m_reset();
    m_nxt  = 0;
    m_lead = 1;
    m_halt = 0;
    m_ov   = 0;
    m_opc  = 0;
    m_oi   = '0;
    m_fc   = 0;
    m_sc   = 0;
  endtask

  function automatic int exp_dir(bit st, bit rd, int tg);
    if (rd) return tg;
    if (m_halt || st) return m_nxt;
    if (m_lead > 0) return m_nxt;
    return (m_nxt + 1) % NMEM;
  endfunction

  task automatic m_step(bit st, bit rd, int tg);
    if (st && !rd) m_sc++;
    if (rd) begin
      m_ov   = 0;
      m_nxt  = tg;
      m_lead = 0;
      m_halt = 0;
    end else if (st) begin
      m_ov = m_ov;
    end else if (m_halt) begin
      m_ov = 0;
    end else if (m_lead > 0) begin
      m_ov = 0;
      m_lead--;
    end else begin
      m_ov  = 1;
      m_opc = m_nxt;
      m_oi  = mem[m_nxt];
      m_fc++;
      if (m_oi == 32'h0) m_halt = 1;
      m_nxt = (m_nxt + 1) % NMEM;
    end
  endtask

  // Entered and left at a negedge.
  task automatic cyc(bit st, bit rd, int tg);
    stall           = st;
    redirect        = rd;
    redirect_target = AW'(tg);
    #1;
    chk("direccion", 32'(direccion), 32'(exp_dir(st, rd, tg)));
    chk("if_valid", 32'(if_valid), 32'(m_ov));
    chk("halted", 32'(halted), 32'(m_halt));
    if (m_ov) begin
      chk("if_pc", 32'(if_pc), 32'(m_opc));
      chk("if_instr", if_instr, m_oi);
    end
    chk("fetch_count", fetch_count, PERF ? 32'(m_fc) : 32'd0);
    chk("stall_count", stall_count, PERF ? 32'(m_sc) : 32'd0);
    @(posedge clk);
    m_step(st, rd, tg);
    @(negedge clk);
  endtask

  task automatic rst_assert();
    stall    = 1'b0;
    redirect = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(if_pc), 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_dir", 32'(direccion), 32'd0);
    chk("rst_fcnt", fetch_count, 32'd0);
    chk("rst_scnt", stall_count, 32'd0);
    @(negedge clk);
  endtask

  task automatic rst_release();
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic fill_add();
    for (int i = 0; i < NMEM; i++) mem[i] = 32'h0200_0020 + 32'(i);
  endtask

  initial begin
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = '0;
    fill_add();
    m_reset();
    @(negedge clk);

    // Reset release and plain sequential fetch
    rst_assert();
    rst_release();
    repeat (6) cyc(0, 0, 0);

    // Stall 3 cycles while if_pc=1
    rst_assert();
    rst_release();
    repeat (3) cyc(0, 0, 0);
    chk("pre_stall_pc", 32'(if_pc), 32'd1);
    repeat (3) cyc(1, 0, 0);
    chk("stall_hold_pc", 32'(if_pc), 32'd1);
    chk("stall_cnt3", stall_count, PERF ? 32'd3 : 32'd0);
    repeat (3) cyc(0, 0, 0);

    // Redirect to 32 while fetching address 3, alone then with stall
    for (int k = 0; k < 2; k++) begin
      rst_assert();
      rst_release();
      repeat (3) cyc(0, 0, 0);
      cyc(k == 1, 1, 32);
      chk("redir_bubble", 32'(if_valid), 32'd0);
      cyc(0, 0, 0);
      chk("redir_tgt_pc", 32'(if_pc), 32'd32);
      repeat (3) cyc(0, 0, 0);
    end

    // HLT at word 1, then resume via redirect to 2
    rst_assert();
    mem[1] = 32'h0;
    rst_release();
    repeat (6) cyc(0, 0, 0);
    chk("hlt_halted", 32'(halted), 32'd1);
    cyc(1, 0, 0);
    cyc(0, 1, 2);
    repeat (4) cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (5) cyc(0, 0, 0);
    fill_add();

    // PC wrap 1022 -> 1023 -> 0
    rst_assert();
    rst_release();
    cyc(0, 1, 1022);
    repeat (5) cyc(0, 0, 0);
    chk("wrap_pc", 32'(if_pc), 32'd2);

    // Random traffic with sparse HLT words and occasional mid-run reset
    rst_assert();
    for (int i = 0; i < NMEM; i++)
      mem[i] = ($urandom_range(0, 39) == 0) ? 32'h0 : ($urandom | 32'h1);
    rst_release();
    for (int n = 0; n < 3000; n++) begin
      bit st, rd;
      int tg;
      if ($urandom_range(0, 399) == 0) begin
        rst_assert();
        rst_release();
      end
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 11) == 0);
      tg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1018, 1023))
                                       : int'($urandom_range(0, NMEM - 1));
      cyc(st, rd, tg);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
